// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready word stream feeding the UART transmitter.
//   in_data  P_WIDTH  word to transmit, qualified by in_vld
//   in_vld   1        producer has a word (fifo rd_vld)
//   in_rdy   1        transmitter can take a word this cycle (fifo rd_rdy)
// master = producer side (fifo read port), slave = transmitter side.
interface uart_tx_if #(
  parameter int P_WIDTH = 8
);
  logic [P_WIDTH-1:0] in_data;
  logic               in_vld;
  logic               in_rdy;

  modport master (output in_data, output in_vld, input in_rdy);
  modport slave  (input in_data, input in_vld, output in_rdy);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter draining a single-clock fifo read port.
// One word is taken per valid/ready handshake and shifted out LSB-first as
// start bit, P_WIDTH data bits, optional parity bit and P_STOP_BITS stop bits.
// Ports:
//   clk    in   system clock, all logic on posedge
//   rst    in   synchronous active-high reset; drops any frame in flight
//   in_if  slave word stream (in_data / in_vld / in_rdy)
//   tx     out  serial line, idle high, registered
//   busy   out  frame in progress, registered alongside tx
module uart_tx #(
  parameter int P_WIDTH        = 8,
  parameter int P_CLKS_PER_BIT = 868,
  parameter int P_PARITY       = 0,
  parameter int P_STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  in_if,
  output logic      tx,
  output logic      busy
);

  localparam int CW = $clog2(P_CLKS_PER_BIT);
  localparam int BW = $clog2(P_WIDTH + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(P_CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(P_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(P_STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      baud_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [P_WIDTH-1:0] shift_reg;
  logic               parity_bit;
  logic               bit_done;
  logic               hs;
  logic               tx_bit;

  // Ready depends on state and rst only, so there is no combinational path
  // from in_vld back to in_rdy through this block.
  assign in_if.in_rdy = (state == S_IDLE) && !rst;
  assign hs           = in_if.in_vld && in_if.in_rdy;
  assign bit_done     = (baud_cnt == BAUD_LAST);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and the line level belonging to the current state.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_nxt = state;
    tx_bit    = 1'b1;
    unique case (state)
      S_IDLE: begin
        if (hs) state_nxt = S_START;
      end
      S_START: begin
        tx_bit = 1'b0;
        if (bit_done) state_nxt = S_DATA;
      end
      S_DATA: begin
        tx_bit = shift_reg[0];
        if (bit_done && (bit_cnt == DATA_LAST))
          state_nxt = (P_PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx_bit = parity_bit;
        if (bit_done) state_nxt = S_STOP;
      end
      S_STOP: begin
        tx_bit = 1'b1;
        if (bit_done && (bit_cnt == STOP_LAST)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: counters, shift register and the registered line outputs.
  // tx and busy are registered from the current state, so the start bit
  // appears one edge after the handshake and busy frames exactly the
  // interval that tx carries a frame.
  always_ff @(posedge clk) begin
    // NOTE: the shift register is an ordinary datapath register, so it is
    // cleared with everything else to keep the reset state fully defined.
    if (rst) begin
      tx         <= 1'b1;
      busy       <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else begin
      tx   <= tx_bit;
      busy <= (state != S_IDLE);

      // Both counters restart on every state change so each state begins
      // with a full bit period.
      if (state_nxt != state) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state != S_IDLE) begin
        baud_cnt <= bit_done ? '0 : baud_cnt + CW'(1);
        if (bit_done) bit_cnt <= bit_cnt + BW'(1);
      end

      if (hs) begin
        shift_reg  <= in_if.in_data;
        // Odd parity sets the bit when the data has an even number of ones.
        parity_bit <= (P_PARITY == 1) ? ~^in_if.in_data : ^in_if.in_data;
      end else if ((state == S_DATA) && bit_done) begin
        shift_reg <= shift_reg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with four parameterisations
// (no parity, even parity, odd parity, two stop bits), all at 4 clocks/bit.
// A fifo model feeds the selected instance; every accepted word is pushed to
// a scoreboard and popped when its frame is decoded from the sampled line.
module tb_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if #(.P_WIDTH(8)) bus0 ();
  uart_tx_if #(.P_WIDTH(8)) bus1 ();
  uart_tx_if #(.P_WIDTH(8)) bus2 ();
  uart_tx_if #(.P_WIDTH(8)) bus3 ();

  logic [7:0] drv_data [4];
  logic       drv_vld  [4];
  wire  [3:0] tx_w;
  wire  [3:0] busy_w;
  wire  [3:0] rdy_w;

  assign bus0.in_data = drv_data[0];
  assign bus0.in_vld  = drv_vld[0];
  assign bus1.in_data = drv_data[1];
  assign bus1.in_vld  = drv_vld[1];
  assign bus2.in_data = drv_data[2];
  assign bus2.in_vld  = drv_vld[2];
  assign bus3.in_data = drv_data[3];
  assign bus3.in_vld  = drv_vld[3];
  assign rdy_w = {bus3.in_rdy, bus2.in_rdy, bus1.in_rdy, bus0.in_rdy};

  uart_tx #(.P_WIDTH(8), .P_CLKS_PER_BIT(CPB), .P_PARITY(0), .P_STOP_BITS(1)) dut_none (
    .clk(clk), .rst(rst), .in_if(bus0.slave), .tx(tx_w[0]), .busy(busy_w[0]));
  uart_tx #(.P_WIDTH(8), .P_CLKS_PER_BIT(CPB), .P_PARITY(2), .P_STOP_BITS(1)) dut_even (
    .clk(clk), .rst(rst), .in_if(bus1.slave), .tx(tx_w[1]), .busy(busy_w[1]));
  uart_tx #(.P_WIDTH(8), .P_CLKS_PER_BIT(CPB), .P_PARITY(1), .P_STOP_BITS(1)) dut_odd (
    .clk(clk), .rst(rst), .in_if(bus2.slave), .tx(tx_w[2]), .busy(busy_w[2]));
  uart_tx #(.P_WIDTH(8), .P_CLKS_PER_BIT(CPB), .P_PARITY(0), .P_STOP_BITS(2)) dut_stop2 (
    .clk(clk), .rst(rst), .in_if(bus3.slave), .tx(tx_w[3]), .busy(busy_w[3]));

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] fifo_q [$];
  logic [7:0] sb_q   [$];
  int         act_sel  = 0;
  bit         noise    = 1'b0;

  logic       tx_s   [4][512];
  logic       rdy_s  [4][512];
  logic       busy_s [4][512];
  int         n_rec = 0;

  // Fifo model: handshake decided from values stable at the negedge,
  // inputs updated just after the posedge.
  initial begin
    bit hs;
    for (int i = 0; i < 4; i++) begin
      drv_data[i] = 8'h00;
      drv_vld[i]  = 1'b0;
    end
    forever begin
      @(negedge clk);
      hs = drv_vld[act_sel] && rdy_w[act_sel];
      @(posedge clk);
      #1;
      if (hs) sb_q.push_back(fifo_q.pop_front());
      for (int i = 0; i < 4; i++) begin
        drv_vld[i] = (i == act_sel) && (fifo_q.size() != 0);
        if (drv_vld[i])                    drv_data[i] = fifo_q[0];
        else if (noise && (i == act_sel))  drv_data[i] = ~drv_data[i];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic record(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        tx_s[i][k]   = tx_w[i];
        rdy_s[i][k]  = rdy_w[i];
        busy_s[i][k] = busy_w[i];
      end
    end
    n_rec = n;
  endtask

  function automatic int find_start(input int sel, input int from);
    for (int k = (from < 1) ? 1 : from; k < n_rec; k++)
      if (tx_s[sel][k-1] === 1'b1 && tx_s[sel][k] === 1'b0) return k;
    return -1;
  endfunction

  // Decodes the frame starting at sample st and compares it with the next
  // scoreboard entry.
  task automatic verify_frame(input int sel, input int st, input int par_mode,
                              input int stops, input string name);
    logic [7:0] exp_d;
    logic [7:0] got_d;
    logic       exp_p;
    logic       stable;
    logic       stop_hi;
    int         pe;
    int         f;
    if (st < 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no start bit within %0d cycles", name, n_rec);
      return;
    end
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: frame seen but no word was handed over", name);
      return;
    end
    exp_d = sb_q.pop_front();
    pe    = (par_mode != 0) ? 1 : 0;
    f     = (1 + 8 + pe + stops) * CPB;
    if (st + f >= n_rec) begin
      n_checks++; n_fail++;
      $display("FAIL %s: frame at %0d runs past the %0d sampled cycles", name, st, n_rec);
      return;
    end
    stable = 1'b1;
    for (int b = 0; b < 9 + pe; b++)
      for (int j = 1; j < CPB; j++)
        if (tx_s[sel][st + b*CPB + j] !== tx_s[sel][st + b*CPB]) stable = 1'b0;
    for (int i = 0; i < 8; i++) got_d[i] = tx_s[sel][st + (1 + i)*CPB];
    stop_hi = 1'b1;
    for (int k = (9 + pe)*CPB; k < f; k++)
      if (tx_s[sel][st + k] !== 1'b1) stop_hi = 1'b0;

    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++;
      $display("FAIL %s stable: a bit changed inside its %0d-cycle period", name, CPB);
    end
    n_checks++;
    if (got_d !== exp_d) begin
      n_fail++;
      $display("FAIL %s data: got 0x%02h expected 0x%02h", name, got_d, exp_d);
    end
    if (pe != 0) begin
      exp_p = (par_mode == 2) ? ($countones(exp_d) % 2 == 1) : ($countones(exp_d) % 2 == 0);
      n_checks++;
      if (tx_s[sel][st + 9*CPB] !== exp_p) begin
        n_fail++;
        $display("FAIL %s parity: got %b expected %b", name, tx_s[sel][st + 9*CPB], exp_p);
      end
    end
    n_checks++;
    if (stop_hi !== 1'b1) begin
      n_fail++;
      $display("FAIL %s stop: line not high for all %0d stop cycles", name, stops*CPB);
    end
    n_checks++;
    if (rdy_s[sel][st + f - 2] !== 1'b0 || rdy_s[sel][st + f - 1] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s length: in_rdy at frame end got %b%b expected 01 (frame %0d cycles)",
               name, rdy_s[sel][st + f - 2], rdy_s[sel][st + f - 1], f);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (tx_w !== 4'hF || busy_w !== 4'h0 || rdy_w !== 4'h0) begin
        n_fail++;
        $display("FAIL reset cycle %0d: tx=%b busy=%b in_rdy=%b expected 1111 0000 0000",
                 c, tx_w, busy_w, rdy_w);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rdy_w !== 4'hF || tx_w !== 4'hF) begin
      n_fail++;
      $display("FAIL reset release: in_rdy=%b tx=%b expected 1111 1111", rdy_w, tx_w);
    end
  endtask

  task automatic test_idle();
    int lows;
    int not_rdy;
    record(30);
    lows = 0;
    not_rdy = 0;
    for (int k = 0; k < n_rec; k++)
      for (int i = 0; i < 4; i++) begin
        if (tx_s[i][k] !== 1'b1) lows++;
        if (rdy_s[i][k] !== 1'b1) not_rdy++;
      end
    n_checks++;
    if (lows != 0 || not_rdy != 0) begin
      n_fail++;
      $display("FAIL idle: %0d low tx samples, %0d not-ready samples, expected 0 and 0",
               lows, not_rdy);
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] exp_bits;
    int         st;
    int         lows;
    int         bad;
    act_sel = 0;
    fifo_q.push_back(8'hA5);
    exp_bits = {1'b1, 8'hA5, 1'b0};
    record(60);
    st = find_start(0, 1);
    if (st > 0 && st + 4*CPB*10 < n_rec) begin
      bad = 0;
      for (int b = 0; b < 10; b++)
        for (int j = 0; j < CPB; j++)
          if (tx_s[0][st + b*CPB + j] !== exp_bits[b]) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL single 0xA5 line: %0d of 40 samples differ from 0,1,0,1,0,0,1,0,1,1", bad);
      end
      lows = 0;
      for (int k = st - 1; k < st + 39; k++) if (rdy_s[0][k] === 1'b0) lows++;
      n_checks++;
      if (lows != 40 || rdy_s[0][st + 39] !== 1'b1) begin
        n_fail++;
        $display("FAIL single in_rdy: %0d low cycles then %b, expected 40 then 1",
                 lows, rdy_s[0][st + 39]);
      end
      n_checks++;
      if (busy_s[0][st + 20] !== 1'b1 || busy_s[0][st - 2] !== 1'b0) begin
        n_fail++;
        $display("FAIL single busy: mid-frame %b before-frame %b, expected 1 and 0",
                 busy_s[0][st + 20], busy_s[0][st - 2]);
      end
    end
    verify_frame(0, st, 0, 1, "single_a5");
  endtask

  task automatic test_back_to_back();
    int st [3];
    act_sel = 0;
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h3C);
    record(150);
    st[0] = find_start(0, 1);
    st[1] = (st[0] < 0) ? -1 : find_start(0, st[0] + 1);
    st[2] = (st[1] < 0) ? -1 : find_start(0, st[1] + 1);
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (st[i] - st[i-1] != 41) begin
        n_fail++;
        $display("FAIL b2b spacing %0d: start-to-start %0d cycles, expected 41",
                 i, st[i] - st[i-1]);
      end
    end
    verify_frame(0, st[0], 0, 1, "b2b_00");
    verify_frame(0, st[1], 0, 1, "b2b_ff");
    verify_frame(0, st[2], 0, 1, "b2b_3c");
  endtask

  task automatic test_parity();
    act_sel = 1;
    fifo_q.push_back(8'h07);
    record(60);
    verify_frame(1, find_start(1, 1), 2, 1, "even_07");
    act_sel = 2;
    fifo_q.push_back(8'h07);
    record(60);
    verify_frame(2, find_start(2, 1), 1, 1, "odd_07");
  endtask

  task automatic test_reset_mid_frame();
    int  wait_cnt;
    bit  seen;
    logic [7:0] dropped;
    act_sel = 0;
    fifo_q.push_back(8'h55);
    fifo_q.push_back(8'h96);
    seen = 1'b0;
    wait_cnt = 0;
    while (!seen && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
      if (tx_w[0] === 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_mid start: no start bit within 100 cycles");
      return;
    end
    // First start-bit sample lies after handshake edge t+1; data bit 3
    // occupies state cycles t+16..t+19, so rst is sampled at edge t+18.
    repeat (16) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid before: tx=%b busy=%b expected data bit 3 = 0 and busy 1",
               tx_w[0], busy_w[0]);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid after: tx=%b busy=%b expected 1 and 0", tx_w[0], busy_w[0]);
    end
    if (sb_q.size() != 0) dropped = sb_q.pop_front();
    record(60);
    verify_frame(0, find_start(0, 1), 0, 1, "rst_mid_next_96");
  endtask

  task automatic test_stop_bits_noise();
    act_sel = 3;
    noise   = 1'b1;
    fifo_q.push_back(8'h5A);
    record(60);
    noise = 1'b0;
    verify_frame(3, find_start(3, 1), 0, 2, "stop2_noise_5a");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_byte();
    test_back_to_back();
    test_parity();
    test_reset_mid_frame();
    test_stop_bits_noise();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
